// File: rtl/mmio_bridge_if.sv
// Processor-side and slave-side bus bundle for the MMIO bridge.
// The bridge takes the slave modport; the environment takes master.
interface mmio_if #(
  parameter int NSLV = 3
);
  logic              p_req;
  logic [31:0]       p_addr;
  logic [3:0]        p_byteen;
  logic [31:0]       p_wdata;
  logic [31:0]       p_pc;
  logic [31:0]       p_rdata;
  logic              p_ready;
  logic              p_stall;
  logic [4:0]        p_exc;
  logic              s_req;
  logic [NSLV-1:0]   s_sel;
  logic [31:0]       s_addr;
  logic [3:0]        s_byteen;
  logic [31:0]       s_wdata;
  logic [31:0]       s_pc;
  logic [NSLV-1:0]   s_ack;
  logic [NSLV*32-1:0] s_rdata;

  modport master (
    output p_req, p_addr, p_byteen, p_wdata, p_pc,
    output s_ack, s_rdata,
    input  p_rdata, p_ready, p_stall, p_exc,
    input  s_req, s_sel, s_addr, s_byteen, s_wdata, s_pc
  );

  modport slave (
    input  p_req, p_addr, p_byteen, p_wdata, p_pc,
    input  s_ack, s_rdata,
    output p_rdata, p_ready, p_stall, p_exc,
    output s_req, s_sel, s_addr, s_byteen, s_wdata, s_pc
  );
endinterface

// File: rtl/mmio_bridge.sv
// MMIO bridge: decodes a processor access onto one of NSLV slaves,
// waits for the slave ack with a timeout, then pulses p_ready once.
module mmio_bridge #(
  parameter int NSLV = 3,
  parameter logic [NSLV*32-1:0] BASE_VEC =
    {32'h7F10, 32'h7F00, 32'h0000},
  parameter logic [NSLV*32-1:0] MASK_VEC =
    {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000},
  parameter logic [NSLV-1:0] WORD_ONLY = 3'b110,
  parameter int TMO = 15
) (
  input logic clk,
  input logic reset,
  mmio_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       pc_q, pc_d;
  logic [NSLV-1:0]   sel_q, sel_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [4:0]        exc_q, exc_d;

  logic [NSLV-1:0]   hit_oh;
  logic              is_wr;
  logic              mis;
  logic              fault;
  logic              ack_hit;
  logic [31:0]       rd_mux;

  // Walk from the top so the lowest matching index is left standing.
  always_comb begin
    hit_oh = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((bus.p_addr & MASK_VEC[i*32 +: 32]) == BASE_VEC[i*32 +: 32]) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  assign is_wr = |bus.p_byteen;
  assign mis   = |bus.p_addr[1:0];

  assign fault = ~|hit_oh
               | (is_wr & mis & (bus.p_byteen == 4'hF))
               | (is_wr & |(hit_oh & WORD_ONLY) & (bus.p_byteen != 4'hF))
               | (~is_wr & mis);

  assign ack_hit = |(bus.s_ack & sel_q);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) rd_mux = rd_mux | bus.s_rdata[i*32 +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.p_req) begin
          rdata_d = '0;
          if (fault) begin
            exc_d   = is_wr ? EXC_ADES : EXC_ADEL;
            state_d = DONE;
          end else begin
            addr_d  = bus.p_addr;
            be_d    = bus.p_byteen;
            wdata_d = bus.p_wdata;
            pc_d    = bus.p_pc;
            sel_d   = hit_oh;
            cnt_d   = '0;
            exc_d   = EXC_NONE;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // An ack on the final allowed cycle still completes normally.
        if (ack_hit) begin
          exc_d   = EXC_NONE;
          rdata_d = (|be_q) ? 32'h0 : rd_mux;
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          exc_d   = (|be_q) ? EXC_ADES : EXC_ADEL;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.s_req    = (state_q == BUSY);
  assign bus.s_sel    = (state_q == BUSY) ? sel_q : '0;
  assign bus.s_addr   = addr_q;
  assign bus.s_byteen = be_q;
  assign bus.s_wdata  = wdata_q;
  assign bus.s_pc     = pc_q;
  assign bus.p_ready  = (state_q == DONE);
  assign bus.p_exc    = (state_q == DONE) ? exc_q : EXC_NONE;
  assign bus.p_rdata  = (state_q == DONE) ? rdata_q : 32'h0;
  assign bus.p_stall  = ((state_q == IDLE) & bus.p_req) | (state_q == BUSY);

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: decode faults, timeout,
// ack ordering, reset abort and back-to-back reads.
module tb_mmio_bridge;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  mmio_if #(.NSLV(3)) bif ();

  mmio_bridge #(.NSLV(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [31:0] D0 = 32'hAAAA_0000;
  localparam logic [31:0] D1 = 32'hBBBB_1111;
  localparam logic [31:0] D2 = 32'hCCCC_2222;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int          t_stall, t_busy, t_ready;
  logic [4:0]  t_exc;
  logic [31:0] t_rdata, t_saddr, t_spc;
  logic [2:0]  t_sel;

  task automatic txn(input logic [31:0] addr,
                     input logic [3:0]  be,
                     input logic [31:0] wd,
                     input logic [31:0] pc,
                     input int          ack_at,
                     input int          bad_at);
    int done;
    done    = -1;
    t_stall = 0;
    t_busy  = 0;
    t_ready = 0;
    t_exc   = '0;
    t_rdata = '0;
    t_saddr = '0;
    t_spc   = '0;
    t_sel   = '0;
    bif.p_req    = 1'b1;
    bif.p_addr   = addr;
    bif.p_byteen = be;
    bif.p_wdata  = wd;
    bif.p_pc     = pc;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bif.p_stall) t_stall++;
      if (bif.s_req) begin
        t_busy++;
        t_sel   = bif.s_sel;
        t_saddr = bif.s_addr;
        t_spc   = bif.s_pc;
        if (t_busy == ack_at) bif.s_ack = bif.s_sel;
        else if (t_busy == bad_at) bif.s_ack = ~bif.s_sel;
      end
      if (bif.p_ready) begin
        t_ready++;
        t_exc   = bif.p_exc;
        t_rdata = bif.p_rdata;
        bif.p_req = 1'b0;
        if (done < 0) done = c;
      end
      @(posedge clk);
      #1;
      bif.s_ack = '0;
      if (done >= 0 && c >= done + 1) break;
    end
    bif.p_req = 1'b0;
  endtask

  initial begin
    int          rc[2];
    logic [2:0]  sl[2];
    logic [31:0] rd[2];
    int          nr;

    bif.p_req    = 1'b0;
    bif.p_addr   = '0;
    bif.p_byteen = '0;
    bif.p_wdata  = '0;
    bif.p_pc     = '0;
    bif.s_ack    = '0;
    bif.s_rdata  = {D2, D1, D0};

    reset = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(bif.p_ready), 0);
    check("rst_exc", 32'(bif.p_exc), 0);
    check("rst_rdata", bif.p_rdata, 0);
    check("rst_sreq", 32'(bif.s_req), 0);
    check("rst_sel", 32'(bif.s_sel), 0);
    check("rst_saddr", bif.s_addr, 0);
    check("rst_sbe", 32'(bif.s_byteen), 0);
    check("rst_swd", bif.s_wdata, 0);
    check("rst_spc", bif.s_pc, 0);
    reset = 1'b1;
    tick();

    // read slave 0, ack on second BUSY cycle
    txn(32'h0000_1004, 4'h0, 32'h0, 32'h0000_0400, 2, 0);
    check("rd0_ready", t_ready, 1);
    check("rd0_exc", 32'(t_exc), 0);
    check("rd0_rdata", t_rdata, D0);
    check("rd0_stall", t_stall, 3);
    check("rd0_busy", t_busy, 2);
    check("rd0_sel", 32'(t_sel), 32'b001);
    check("rd0_saddr", t_saddr, 32'h0000_1004);
    check("rd0_spc", t_spc, 32'h0000_0400);

    // partial write to a word-only slave
    txn(32'h0000_7F04, 4'b0011, 32'h1234, 32'h0, 1, 0);
    check("wo_ready", t_ready, 1);
    check("wo_exc", 32'(t_exc), 5);
    check("wo_busy", t_busy, 0);
    check("wo_stall", t_stall, 1);
    check("wo_rdata", t_rdata, 0);

    // no hit
    txn(32'h0001_0000, 4'h0, 32'h0, 32'h0, 1, 0);
    check("nohit_ready", t_ready, 1);
    check("nohit_exc", 32'(t_exc), 4);
    check("nohit_rdata", t_rdata, 0);
    check("nohit_stall", t_stall, 1);
    check("nohit_busy", t_busy, 0);

    // write to slave 1, never acked
    txn(32'h0000_7F08, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, 0);
    check("tmo_ready", t_ready, 1);
    check("tmo_exc", 32'(t_exc), 5);
    check("tmo_busy", t_busy, 15);
    check("tmo_stall", t_stall, 16);
    check("tmo_rdata", t_rdata, 0);

    // ack on the last allowed cycle wins
    txn(32'h0000_7F08, 4'hF, 32'hDEAD_BEEF, 32'h0, 15, 0);
    check("late_ready", t_ready, 1);
    check("late_exc", 32'(t_exc), 0);
    check("late_busy", t_busy, 15);
    check("late_rdata", t_rdata, 0);

    // misaligned read and misaligned full-word write
    txn(32'h0000_1002, 4'h0, 32'h0, 32'h0, 1, 0);
    check("misr_exc", 32'(t_exc), 4);
    check("misr_busy", t_busy, 0);
    txn(32'h0000_1002, 4'hF, 32'h0, 32'h0, 1, 0);
    check("misw_exc", 32'(t_exc), 5);
    check("misw_busy", t_busy, 0);

    // partial write to a byte-capable slave is legal
    txn(32'h0000_1001, 4'b0010, 32'h0000_5500, 32'h0000_0800, 1, 0);
    check("bw_exc", 32'(t_exc), 0);
    check("bw_busy", t_busy, 1);
    check("bw_saddr", t_saddr, 32'h0000_1001);
    check("bw_rdata", t_rdata, 0);
    check("bw_swd", bif.s_wdata, 32'h0000_5500);
    check("bw_sbe", 32'(bif.s_byteen), 32'b0010);

    // acks from unselected slaves are ignored
    txn(32'h0000_7F1C, 4'h0, 32'h0, 32'h0, 3, 1);
    check("oth_busy", t_busy, 3);
    check("oth_sel", 32'(t_sel), 32'b100);
    check("oth_rdata", t_rdata, D2);
    check("oth_exc", 32'(t_exc), 0);

    // reset in the second BUSY cycle aborts, late ack ignored
    bif.p_req    = 1'b1;
    bif.p_addr   = 32'h0000_1004;
    bif.p_byteen = 4'h0;
    tick();
    check("ab_sreq1", 32'(bif.s_req), 1);
    tick();
    reset     = 1'b0;
    bif.p_req = 1'b0;
    tick();
    check("ab_sreq", 32'(bif.s_req), 0);
    check("ab_ready0", 32'(bif.p_ready), 0);
    reset     = 1'b1;
    bif.s_ack = 3'b001;
    tick();
    bif.s_ack = '0;
    check("ab_ready1", 32'(bif.p_ready), 0);
    check("ab_sreq2", 32'(bif.s_req), 0);
    tick();
    check("ab_ready2", 32'(bif.p_ready), 0);

    // back-to-back reads with p_req held
    nr    = 0;
    rc[0] = 0;
    rc[1] = 0;
    sl[0] = '0;
    sl[1] = '0;
    rd[0] = '0;
    rd[1] = '0;
    bif.p_req    = 1'b1;
    bif.p_addr   = 32'h0000_1008;
    bif.p_byteen = 4'h0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bif.s_req) begin
        bif.s_ack = bif.s_sel;
        if (nr < 2) sl[nr] = bif.s_sel;
      end
      if (bif.p_ready) begin
        if (nr < 2) begin
          rc[nr] = c;
          rd[nr] = bif.p_rdata;
        end
        nr++;
        if (nr == 1) bif.p_addr = 32'h0000_7F14;
        else bif.p_req = 1'b0;
      end
      @(posedge clk);
      #1;
      bif.s_ack = '0;
      if (nr >= 2 && c > rc[1] + 1) break;
    end
    bif.p_req = 1'b0;
    check("b2b_count", nr, 2);
    check("b2b_sel0", 32'(sl[0]), 32'b001);
    check("b2b_sel1", 32'(sl[1]), 32'b100);
    check("b2b_rd0", rd[0], D0);
    check("b2b_rd1", rd[1], D2);
    check("b2b_gap", rc[1] - rc[0], 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
